cam_frame_dma: RTL
==================

Name: cam_frame_dma

Overview:
- Upstream write-DMA stage for the frame SRAM.
- Takes an 8-bit camera byte stream (valid/ready plus start-of-frame flag) and turns each accepted byte into one registered byte write (dma_wr_en/addr/data) into the SRAM's DMA write port.
- Frame-synchronises on SOF, places exactly cfg_len bytes at cfg_base, then reports done.
- Optional continuous mode re-arms for the next frame automatically.

Parameters:
- ADDR_W, 16, width of the SRAM byte address and of cfg_base/cfg_len.
- CNT_W, 8, width of the completed-frame counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle arm pulse; honoured only in IDLE
- abort  in  1  one-cycle pulse; returns to IDLE from any state
- cfg_continuous  in  1  sampled on start; 1 = re-arm after each frame
- cfg_base  in  ADDR_W  SRAM byte address of frame byte 0; sampled on start
- cfg_len  in  ADDR_W  frame length in bytes; sampled on start
- s_valid  in  1  stream byte valid
- s_data  in  8  stream byte
- s_sof  in  1  qualifies s_data as first byte of a frame
- s_ready  out  1  stream accept
- dma_wr_en  out  1  SRAM byte write strobe
- dma_wr_addr  out  ADDR_W  SRAM byte address
- dma_wr_data  out  8  SRAM byte data
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse per completed frame
- err_short  out  1  sticky: SOF arrived mid-frame; cleared on start
- frame_cnt  out  CNT_W  completed frames since last start; wraps

Behaviour:
- Reset values:
  - state = IDLE.
  - s_ready, dma_wr_en, dma_wr_addr, dma_wr_data, busy, done, err_short, frame_cnt all 0.
- Accepted beat = s_valid && s_ready.
- s_ready is 1 in WAIT_SOF and CAPTURE, 0 otherwise. The SRAM never stalls DMA writes, so no backpressure from downstream.
- State IDLE:
  - start with cfg_len != 0 → latch base/len/continuous, clear err_short and frame_cnt, go to WAIT_SOF.
  - start with cfg_len == 0 → ignored.
- State WAIT_SOF:
  - Accepted beats without s_sof are discarded (no write).
  - Accepted beat with s_sof → write byte at base, offset = 1, go to CAPTURE. If len == 1, take the frame-complete path instead.
- State CAPTURE:
  - Each accepted beat without s_sof writes at base + offset, then offset increments.
  - The beat writing offset len-1 completes the frame: done pulses on the same cycle dma_wr_en shows that write, and frame_cnt increments.
  - After completion: continuous → WAIT_SOF; otherwise → IDLE.
- Mid-frame SOF: an accepted beat with s_sof in CAPTURE sets err_short, restarts the frame (byte written at base, offset = 1), and does not pulse done or increment frame_cnt.
- Write timing:
  - dma_wr_en/addr/data are registered: an accepted beat in cycle N appears on the write port in cycle N+1 for exactly one cycle.
  - Back-to-back beats give one write per cycle.
- Address arithmetic: dma_wr_addr = (base + offset) mod 2^ADDR_W, so frames that cross the top of memory wrap to 0.
- abort:
  - Takes priority over any beat in the same cycle; that beat is not accepted. s_ready is forced 0 that cycle.
  - A write already registered from the previous cycle still appears.
  - Next state is IDLE; no done pulse. err_short and frame_cnt are held.
- start while busy: ignored.
- start and abort in the same cycle: abort wins.
- rst mid-frame: all outputs return to reset values on the next edge; no further writes.

Test Plan:
- base=0x0100, len=4, continuous=0. Stream 0xA0 with sof, then 0xA1, 0xA2, 0xA3 back-to-back → writes 0x0100..0x0103 = A0..A3 on consecutive cycles, each 1 cycle after its beat. done pulses with the 0x0103 write; frame_cnt=1; busy=0 afterwards.
- Armed, stream 0x11, 0x22 without sof, then 0x33 with sof, len=1 → only 0x33 is written, at base. 0x11/0x22 are dropped but still accepted (s_ready=1).
- base=0xFFFE, len=4 → writes go to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- continuous=1, len=2, three frames with idle gaps and s_valid toggling → frame_cnt=3, exactly 3 done pulses, busy stays 1, no writes during gaps.
- len=4. Send sof+2 bytes, then a new sof and 3 more bytes → err_short=1. Second frame occupies base..base+3; one done; frame_cnt=1.
- Abort after 2 bytes of a len=8 frame, with a beat valid in the abort cycle → that beat is not written, state=IDLE, no done. A start with len=0 is then ignored (busy stays 0).

Source files
------------

// File: rtl/cam_frame_dma.sv
// Camera byte-stream to SRAM write-DMA: syncs on SOF, writes cfg_len bytes
// from cfg_base (address wraps at the top of memory), pulses done per frame.
module cam_frame_dma #(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              cfg_continuous,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_len,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_sof,
  output logic              s_ready,
  output logic              dma_wr_en,
  output logic [ADDR_W-1:0] dma_wr_addr,
  output logic [7:0]        dma_wr_data,
  output logic              busy,
  output logic              done,
  output logic              err_short,
  output logic [CNT_W-1:0]  frame_cnt
);

  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] base, len, offset, offset_n, wr_off;
  logic              cont;
  logic              beat, wr_n, done_n, err_set, arm;

  assign s_ready = (state != IDLE) && !abort;
  assign busy    = (state != IDLE);
  assign beat    = s_valid && s_ready;

  always_comb begin
    state_n  = state;
    offset_n = offset;
    wr_off   = offset;
    wr_n     = 1'b0;
    done_n   = 1'b0;
    err_set  = 1'b0;
    arm      = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start && cfg_len != '0) begin
            arm     = 1'b1;
            state_n = WAIT_SOF;
          end
        end
        WAIT_SOF: begin
          if (beat && s_sof) begin
            wr_n     = 1'b1;
            wr_off   = '0;
            offset_n = ADDR_W'(1);
            if (len == ADDR_W'(1)) begin
              done_n  = 1'b1;
              state_n = cont ? WAIT_SOF : IDLE;
            end else begin
              state_n = CAPTURE;
            end
          end
        end
        CAPTURE: begin
          if (beat) begin
            wr_n = 1'b1;
            if (s_sof) begin
              // Mid-frame SOF restarts the frame at base; it never completes one.
              err_set  = 1'b1;
              wr_off   = '0;
              offset_n = ADDR_W'(1);
            end else begin
              offset_n = offset + ADDR_W'(1);
              if (offset == len - ADDR_W'(1)) begin
                done_n  = 1'b1;
                state_n = cont ? WAIT_SOF : IDLE;
              end
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      base        <= '0;
      len         <= '0;
      cont        <= 1'b0;
      offset      <= '0;
      dma_wr_en   <= 1'b0;
      dma_wr_addr <= '0;
      dma_wr_data <= '0;
      done        <= 1'b0;
      err_short   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state     <= state_n;
      offset    <= offset_n;
      dma_wr_en <= wr_n;
      done      <= done_n;
      if (wr_n) begin
        dma_wr_addr <= base + wr_off;
        dma_wr_data <= s_data;
      end
      if (arm) begin
        base      <= cfg_base;
        len       <= cfg_len;
        cont      <= cfg_continuous;
        err_short <= 1'b0;
        frame_cnt <= '0;
      end else begin
        if (err_set) err_short <= 1'b1;
        if (done_n)  frame_cnt <= frame_cnt + CNT_W'(1);
      end
    end
  end

endmodule
